// File: rtl/alu_resp_unit_pkg.sv
// Shared ALU defines: function encoding, response metadata and FIFO occupancy helpers.
package alu_resp_unit_pkg;

    localparam int unsigned ALU_FUNCT_WIDTH = 3;
    localparam int unsigned ALU_FUNCT_COUNT = 6;
    localparam int unsigned TAG_WIDTH       = 4;

    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_AND = 3'd0;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_OR  = 3'd1;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_XOR = 3'd2;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_NOR = 3'd3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_ADD = 3'd4;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SUB = 3'd5;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic                 equal;
        logic                 zero;
        logic                 overflow;
        logic                 err;
    } rsp_meta_t;

    function automatic logic funct_defined(input logic [ALU_FUNCT_WIDTH-1:0] f);
        return 32'(f) < ALU_FUNCT_COUNT;
    endfunction

    // Two-entry occupancy transition; simultaneous push and pop in ONE stays ONE.
    function automatic occ_state_e occ_next(input occ_state_e s, input logic push, input logic pop);
        occ_state_e n;
        n = s;
        case (s)
            OCC_EMPTY: if (push) n = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      n = OCC_FULL;
                else if (pop && !push) n = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) n = OCC_ONE;
            default:   n = OCC_EMPTY;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_resp_unit_alu.sv
// Combinational ALU (module alu): logic ops, add/sub with signed overflow, undefined-code error.
module alu
    import alu_resp_unit_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]               x,
    input  logic [N-1:0]               y,
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    output logic [N-1:0]               z,
    output logic                       equal,
    output logic                       zero,
    output logic                       overflow,
    output logic                       err
);

    logic [N-1:0] sum;
    logic [N-1:0] diff;

    assign sum  = x + y;
    assign diff = x - y;

    always_comb begin
        z        = '0;
        overflow = 1'b0;
        err      = !funct_defined(funct);
        case (funct)
            ALU_FUNCT_AND: z = x & y;
            ALU_FUNCT_OR:  z = x | y;
            ALU_FUNCT_XOR: z = x ^ y;
            ALU_FUNCT_NOR: z = ~(x | y);
            ALU_FUNCT_ADD: begin
                z        = sum;
                overflow = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
            end
            ALU_FUNCT_SUB: begin
                z        = diff;
                overflow = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
            end
            default: z = '0;
        endcase
        // Flags are suppressed entirely for an undefined code.
        equal = !err && (x == y);
        zero  = !err && (z == '0);
    end

endmodule

// File: rtl/alu_resp_unit.sv
// ALU request/response wrapper with a 2-entry in-order response FIFO.
// Optional statistics counters enabled by defining ALU_RESP_STATS_EN.
module alu_resp_unit
    import alu_resp_unit_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef ALU_RESP_STATS_EN
    output logic [15:0]                stat_ops,
    output logic [7:0]                 stat_errs,
`endif
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [N-1:0]               req_x,
    input  logic [N-1:0]               req_y,
    input  logic [ALU_FUNCT_WIDTH-1:0] req_funct,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N-1:0]               rsp_z,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    output logic                       rsp_equal,
    output logic                       rsp_zero,
    output logic                       rsp_overflow,
    output logic                       rsp_err
);

    logic [N-1:0] alu_z;
    logic         alu_equal;
    logic         alu_zero;
    logic         alu_overflow;
    logic         alu_err;
    rsp_meta_t    alu_meta;

    logic [N-1:0] z_mem    [2];
    rsp_meta_t    meta_mem [2];
    logic         wptr;
    logic         rptr;
    occ_state_e   state;
    occ_state_e   state_next;
    logic         push;
    logic         pop;

    alu #(.N(N)) u_alu (
        .x        (req_x),
        .y        (req_y),
        .funct    (req_funct),
        .z        (alu_z),
        .equal    (alu_equal),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .err      (alu_err)
    );

    assign alu_meta = '{tag: req_tag, equal: alu_equal, zero: alu_zero,
                        overflow: alu_overflow, err: alu_err};

    assign push       = req_valid && req_ready;
    assign pop        = rsp_valid && rsp_ready;
    assign state_next = occ_next(state, push, pop);

    // Occupancy FSM; handshake outputs are registered copies derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next != OCC_FULL);
            rsp_valid <= (state_next != OCC_EMPTY);
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
        end
    end

    // Payload storage needs no reset: validity is carried by the FSM alone.
    always_ff @(posedge clk) begin
        if (push) begin
            z_mem[wptr]    <= alu_z;
            meta_mem[wptr] <= alu_meta;
        end
    end

    assign rsp_z        = z_mem[rptr];
    assign rsp_tag      = meta_mem[rptr].tag;
    assign rsp_equal    = meta_mem[rptr].equal;
    assign rsp_zero     = meta_mem[rptr].zero;
    assign rsp_overflow = meta_mem[rptr].overflow;
    assign rsp_err      = meta_mem[rptr].err;

`ifdef ALU_RESP_STATS_EN
    // Saturating counts of accepted requests and of those that hit an undefined code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (push) begin
            if (stat_ops != 16'hFFFF)           stat_ops  <= stat_ops + 16'd1;
            if (alu_err && stat_errs != 8'hFF) stat_errs <= stat_errs + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_resp_unit.sv
// Self-checking bench for alu_resp_unit: queue-based response model plus directed literal checks.
module tb_alu_resp_unit;
    import alu_resp_unit_pkg::*;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        logic        eq;
        logic        zr;
        logic        ov;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic [2:0]  req_funct = '0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_z;
    logic [3:0]  rsp_tag;
    logic        rsp_equal;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        rsp_err;
`ifdef ALU_RESP_STATS_EN
    logic [15:0] stat_ops;
    logic [7:0]  stat_errs;
    int          exp_ops = 0;
    int          exp_errs = 0;
`endif

    int    n_checks = 0;
    int    n_fails  = 0;
    int    edges    = 0;
    int    cyc      = 0;
    resp_t exp_q[$];
    resp_t got[$];
    int    got_cyc[$];

    alu_resp_unit #(.N(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef ALU_RESP_STATS_EN
        .stat_ops     (stat_ops),
        .stat_errs    (stat_errs),
`endif
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_funct    (req_funct),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_z        (rsp_z),
        .rsp_tag      (rsp_tag),
        .rsp_equal    (rsp_equal),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the ALU definition, using wide signed arithmetic.
    function automatic resp_t model(input logic [2:0] f, input logic [31:0] x,
                                    input logic [31:0] y, input logic [3:0] t);
        resp_t  r;
        longint sx;
        longint sy;
        longint wide;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        r.z   = '0;
        r.ov  = 1'b0;
        r.err = 1'b0;
        r.tag = t;
        case (f)
            ALU_FUNCT_AND: r.z = x & y;
            ALU_FUNCT_OR:  r.z = x | y;
            ALU_FUNCT_XOR: r.z = x ^ y;
            ALU_FUNCT_NOR: r.z = ~(x | y);
            ALU_FUNCT_ADD: begin
                wide = sx + sy;
                r.z  = wide[31:0];
                r.ov = (wide != longint'($signed(r.z)));
            end
            ALU_FUNCT_SUB: begin
                wide = sx - sy;
                r.z  = wide[31:0];
                r.ov = (wide != longint'($signed(r.z)));
            end
            default: r.err = 1'b1;
        endcase
        r.eq = !r.err && (x == y);
        r.zr = !r.err && (r.z == 32'd0);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
        cyc <= cyc + 1;
    end

    // Per-cycle comparison against the model, then model update for the coming edge.
    always @(negedge clk) begin
        resp_t obs;
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            exp_q.delete();
`ifdef ALU_RESP_STATS_EN
            exp_ops  = 0;
            exp_errs = 0;
`endif
        end else begin
            chk("req_ready", 64'(req_ready), 64'(edges > 0 && exp_q.size() < 2));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
            obs = '{z: rsp_z, tag: rsp_tag, eq: rsp_equal, zr: rsp_zero, ov: rsp_overflow, err: rsp_err};
            if (rsp_valid && exp_q.size() != 0) begin
                chk("rsp_z",        64'(obs.z),   64'(exp_q[0].z));
                chk("rsp_tag",      64'(obs.tag), 64'(exp_q[0].tag));
                chk("rsp_equal",    64'(obs.eq),  64'(exp_q[0].eq));
                chk("rsp_zero",     64'(obs.zr),  64'(exp_q[0].zr));
                chk("rsp_overflow", 64'(obs.ov),  64'(exp_q[0].ov));
                chk("rsp_err",      64'(obs.err), 64'(exp_q[0].err));
            end
`ifdef ALU_RESP_STATS_EN
            chk("stat_ops",  64'(stat_ops),  64'(exp_ops));
            chk("stat_errs", 64'(stat_errs), 64'(exp_errs));
`endif
            if (rsp_valid && rsp_ready) begin
                got.push_back(obs);
                got_cyc.push_back(cyc);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(model(req_funct, req_x, req_y, req_tag));
`ifdef ALU_RESP_STATS_EN
                if (exp_ops < 16'hFFFF) exp_ops++;
                if (req_funct >= 3'(ALU_FUNCT_COUNT) && exp_errs < 8'hFF) exp_errs++;
`endif
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_funct = f;
        req_x     = x;
        req_y     = y;
        req_tag   = t;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    function automatic resp_t first_got();
        resp_t r;
        r = '{z: 32'hDEADBEEF, tag: 4'hF, eq: 1'bx, zr: 1'bx, ov: 1'bx, err: 1'bx};
        if (got.size() != 0) r = got[0];
        return r;
    endfunction

    initial begin
        logic [31:0] ez[6];
        logic [2:0]  fn[6];
        logic [31:0] sz[3];
        resp_t       r;
        int          n;
        ez = '{32'd1068, 32'd2047, 32'd979, 32'hFFFFF800, 32'd3115, 32'd467};
        fn = '{ALU_FUNCT_AND, ALU_FUNCT_OR, ALU_FUNCT_XOR, ALU_FUNCT_NOR, ALU_FUNCT_ADD, ALU_FUNCT_SUB};
        sz = '{32'd1068, 32'd2047, 32'd979};

        #2;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_no_edge_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("first_edge_ready", 64'(req_ready), 64'd1);

        // Back-to-back logic/arith stream with the consumer always ready.
        rsp_ready = 1'b1;
        got.delete();
        got_cyc.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) send(fn[i], 32'd1791, 32'd1324, 4'(i));
        drain();
        chk("stream_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            chk("stream_z",   64'(got[i].z),   64'(ez[i]));
            chk("stream_tag", 64'(got[i].tag), 64'(i));
            chk("stream_cyc", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
        end

        got.delete();
        send(ALU_FUNCT_ADD, 32'h7FFFFFFF, 32'd1, 4'd6);
        drain();
        r = first_got();
        chk("ovf_z",   64'(r.z),   64'h80000000);
        chk("ovf_ov",  64'(r.ov),  64'd1);
        chk("ovf_err", 64'(r.err), 64'd0);

        got.delete();
        send(ALU_FUNCT_SUB, 32'd5, 32'd5, 4'd7);
        drain();
        r = first_got();
        chk("sub_z",     64'(r.z),  64'd0);
        chk("sub_zero",  64'(r.zr), 64'd1);
        chk("sub_equal", 64'(r.eq), 64'd1);

        got.delete();
        send(3'd7, 32'd5, 32'd9, 4'd11);
        drain();
        r = first_got();
        chk("undef_err", 64'(r.err), 64'd1);
        chk("undef_z",   64'(r.z),   64'd0);
        chk("undef_ov",  64'(r.ov),  64'd0);
`ifdef ALU_RESP_STATS_EN
        chk("stat_errs_lit", 64'(stat_errs), 64'd1);
        chk("stat_ops_lit",  64'(stat_ops),  64'd9);
`endif

        // Back-pressure: two fill the FIFO, the third waits until the consumer drains.
        got.delete();
        rsp_ready = 1'b0;
        send(ALU_FUNCT_AND, 32'd1791, 32'd1324, 4'd8);
        send(ALU_FUNCT_OR,  32'd1791, 32'd1324, 4'd9);
        req_valid = 1'b1;
        req_funct = ALU_FUNCT_XOR;
        req_tag   = 4'd10;
        @(negedge clk);
        chk("stall_req_ready", 64'(req_ready), 64'd0);
        chk("stall_z0",        64'(rsp_z),     64'd1068);
        repeat (3) @(negedge clk);
        chk("stall_z_hold",    64'(rsp_z),     64'd1068);
        chk("stall_tag_hold",  64'(rsp_tag),   64'd8);
        chk("stall_valid",     64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("stall_third_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
        chk("stall_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            chk("stall_order_tag", 64'(got[i].tag), 64'(8 + i));
            chk("stall_order_z",   64'(got[i].z),   64'(sz[i]));
        end

        // Reset while FULL must discard both entries at once.
        rsp_ready = 1'b0;
        send(ALU_FUNCT_ADD, 32'd1, 32'd2, 4'd12);
        send(ALU_FUNCT_ADD, 32'd3, 32'd4, 4'd13);
        @(negedge clk);
        chk("full_before_rst", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        got.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_count", 64'(got.size()), 64'd0);
        chk("no_stale_valid", 64'(rsp_valid),  64'd0);
        send(ALU_FUNCT_ADD, 32'd2, 32'd3, 4'd14);
        drain();
        r = first_got();
        chk("post_rst_z",   64'(r.z),   64'd5);
        chk("post_rst_tag", 64'(r.tag), 64'd14);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_resp_unit.md
ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

Interface
REQ-001 The block SHALL have parameter N, default 32, for the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-006 The block SHALL have ports req_x and req_y, input, N bits each: operands.
REQ-007 The block SHALL have port req_funct, input, ALU_FUNCT_WIDTH bits: the operation code from the shared ALU function encoding.
REQ-008 The block SHALL have port req_tag, input, 4 bits: an opaque ID returned unchanged with the response.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the response this cycle.
REQ-011 The block SHALL have ports rsp_z (output, N bits: result) and rsp_tag (output, 4 bits: the request tag).
REQ-012 The block SHALL have ports rsp_equal, rsp_zero and rsp_overflow, output, 1 bit each: ALU flags.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: req_funct was not a defined ALU function.

Function
REQ-014 A request SHALL transfer when req_valid && req_ready is high at a rising clk edge; a response SHALL transfer when rsp_valid && rsp_ready is high at a rising clk edge.
REQ-015 The block SHALL compute the result combinationally from the request and write the result, flags, tag and err into a 2-entry in-order response FIFO on the accepting edge, so that rsp_valid is high in the next cycle (latency 1).
REQ-016 Occupancy SHALL be tracked by a state machine: EMPTY→ONE on push; ONE→FULL on push without pop; ONE→EMPTY on pop without push; FULL→ONE on pop; push and pop together in ONE SHALL keep the state ONE.
REQ-017 req_ready SHALL equal (state != FULL), registered-state only, with no combinational path from rsp_ready to req_ready.
REQ-018 rsp_valid SHALL equal (state != EMPTY), and the rsp_* outputs SHALL present the oldest entry.
REQ-019 While rsp_valid is high and rsp_ready is low, the rsp_* outputs SHALL stay stable.
REQ-020 For an undefined req_funct, the block SHALL return rsp_z = 0, all flags = 0 and rsp_err = 1, and it SHALL still accept and respond to the request.
REQ-021 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-022 While rst_n is low, the block SHALL hold state EMPTY and both pointers at 0, and drive rsp_valid = 0 and req_ready = 0.
REQ-023 The block SHALL drive req_ready = 1 from the first clock edge after rst_n deasserts.
REQ-024 An rst_n assertion mid-operation SHALL discard all buffered responses immediately, with no response emitted for them.

Configuration
REQ-025 When the macro ALU_RESP_STATS_EN is defined, the block SHALL add output stat_ops (16 bits: accepted requests, saturating at 0xFFFF) and output stat_errs (8 bits: requests with rsp_err, saturating at 0xFF), both reset to 0.
REQ-026 When ALU_RESP_STATS_EN is undefined, the block SHALL have neither the stat_ops/stat_errs ports nor their counters.

Structure
REQ-027 ALU_FUNCT_WIDTH, the ALU_FUNCT_* codes and the count of defined functions SHALL come from the shared ALU defines package, and the block SHALL not redefine them locally.
REQ-028 The block SHALL instantiate the existing combinational alu module as its sole sub-module, and the block itself SHALL hold only the FIFO, the state machine and the statistics counters.

Verification
REQ-029 A bench SHALL drive x=1791, y=1324 with AND/OR/XOR/NOR/ADD/SUB back-to-back under rsp_ready=1 and require z=1068/2047/979/0xFFFFF800/3115/467, one per cycle, with tags in order.
REQ-030 A bench SHALL drive ADD with x=0x7FFFFFFF, y=1 and require z=0x80000000, overflow=1, err=0.
REQ-031 A bench SHALL drive SUB with x=y=5 and require z=0, zero=1, equal=1.
REQ-032 A bench SHALL hold rsp_ready=0 while issuing 3 requests and require that two are accepted, req_ready=0 on the third, and the outputs stay stable; on rsp_ready=1 it SHALL require that the responses drain in order and the third is then accepted.
REQ-033 A bench SHALL issue an undefined funct code and require err=1, z=0; with ALU_RESP_STATS_EN defined it SHALL require stat_errs to increment by 1.
REQ-034 A bench SHALL assert rst_n low while the FIFO is FULL and require rsp_valid=0 immediately, with no stale response after release.
